// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg
//   Shared types and constants for the instruction-fetch stage.
//   - if_state_e    : fetch FSM state encoding
//   - fetch_entry_t : {pc, inst} pair held in the skid buffer
//   - word_align()  : clears the byte-offset bits of an address
package inst_fetch_pkg;

  localparam int          WORD         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;
  localparam logic [31:0] NOP_INST     = 32'h0340_0000;  // andi r0,r0,0

  typedef enum logic [1:0] {
    IF_BOOT  = 2'd0,
    IF_RUN   = 2'd1,
    IF_REDIR = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [WORD-1:0] pc;
    logic [WORD-1:0] inst;
  } fetch_entry_t;

  function automatic logic [WORD-1:0] word_align(input logic [WORD-1:0] addr);
    return {addr[WORD-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if
//   Bundles the fetch stage's memory port, redirect input and ID handshake.
//   master : the fetch stage (drives imem_req/imem_addr and the if_* outputs)
//   slave  : the environment (memory, EX redirect, decoder)
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic            imem_req;
  logic [WORD-1:0] imem_addr;
  logic [WORD-1:0] imem_rdata;
  logic            br_taken;
  logic [WORD-1:0] br_target;
  logic            if_valid;
  logic            id_ready;
  logic [WORD-1:0] if_inst;
  logic [WORD-1:0] if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_inst, if_pc,
    input  imem_rdata, br_taken, br_target, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_inst, if_pc,
    output imem_rdata, br_taken, br_target, id_ready
  );

endinterface

// File: rtl/inst_fetch_fifo.sv
// inst_fifo
//   DEPTH-entry synchronous FIFO of {pc, inst} pairs used as the fetch skid buffer.
//   Ports: clk, rstn (async active-low), i_push/i_data, i_pop, i_flush
//          (wins over push), o_count (occupancy), o_head (oldest entry, no bypass).
module inst_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  fetch_entry_t             i_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output fetch_entry_t             o_head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_rd;
  logic [AW-1:0]  r_wr;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign w_push = i_push & ~i_flush;
  assign w_pop  = i_pop & (r_count != '0) & ~i_flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Payload storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  // The upstream credit rule should make this unreachable.
  always_ff @(posedge clk) begin
    if (rstn && w_push && !w_pop)
      assert (r_count < (AW+1)'(DEPTH));
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch
//   IF stage: owns the PC, issues one word fetch per cycle to a 1-cycle-latency
//   instruction memory, buffers responses in inst_fifo and hands them to ID over
//   valid/ready. A br_taken pulse flushes everything younger and refetches.
//   Ports: clk, rstn (async active-low), bus (inst_fetch_if.master).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IF_BOOT  | first cycle after reset, no request
//   IF_RUN   | normal fetch, issue while buffer credit is available
//   IF_REDIR | bubble after a redirect; pc_f already holds the target
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rstn,
  inst_fetch_if.master      bus
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  if_state_e       r_state;
  logic [WORD-1:0] r_pc_f;
  logic [WORD-1:0] r_req_pc;
  logic            r_inflight;
  logic            r_kill;

  logic [CW-1:0]   w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;
  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  logic [CW:0]     w_occ;

  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid & bus.id_ready;

  // Occupancy the buffer will have once this cycle's pop and pending response
  // settle; issuing only below BUF_DEPTH leaves room for the new response.
  // Depending on id_ready here keeps 1 inst/cycle with only two entries.
  assign w_occ   = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign w_issue = (r_state == IF_RUN) & ~bus.br_taken
                 & (w_occ < (CW+1)'(BUF_DEPTH));

  // A response belonging to a fetch issued before a redirect is discarded.
  assign w_push      = r_inflight & ~r_kill;
  assign w_push_data = '{pc: r_req_pc, inst: bus.imem_rdata};

  inst_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.br_taken),
    .i_data  (w_push_data),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IF_BOOT;
      r_pc_f     <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
    end else begin
      r_kill <= bus.br_taken;
      if (bus.br_taken) begin
        r_state    <= IF_REDIR;
        r_pc_f     <= word_align(bus.br_target);
        r_inflight <= 1'b0;
      end else begin
        case (r_state)
          IF_BOOT:  r_state <= IF_RUN;
          IF_RUN:   r_state <= IF_RUN;
          IF_REDIR: r_state <= IF_RUN;
          default:  r_state <= IF_BOOT;
        endcase
        if (w_issue) begin
          r_req_pc   <= r_pc_f;
          r_pc_f     <= r_pc_f + 32'd4;
          r_inflight <= 1'b1;
        end else begin
          r_inflight <= 1'b0;
        end
      end
    end
  end

  assign bus.imem_req  = w_issue;
  assign bus.imem_addr = r_pc_f;
  assign bus.if_valid  = w_valid;
  assign bus.if_inst   = w_valid ? w_head.inst : '0;
  assign bus.if_pc     = w_valid ? w_head.pc   : '0;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Synchronous instruction memory: word depends on address, 1-cycle latency.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5a5a_c3c3;
  endfunction

  logic [31:0] mem_q;
  always @(posedge clk) if (bus.imem_req) mem_q <= mem_word(bus.imem_addr);
  assign bus.imem_rdata = mem_q;

  // Reference model: queue of buffered PCs, next fetch address, pending response.
  logic [31:0] m_q[$];
  logic [31:0] m_fetch;
  logic [31:0] m_infl_pc;
  bit          m_boot;
  bit          m_redir;
  bit          m_infl;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fetch = RST_PC;
    m_boot  = 1'b1;
    m_redir = 1'b0;
    m_infl  = 1'b0;
    m_infl_pc = '0;
  endtask

  // Compare all outputs against the model mid-cycle, then advance the model.
  task automatic tick();
    bit          pop;
    bit          req;
    bit          br;
    logic [31:0] tgt;
    logic [31:0] hp;
    @(negedge clk);
    pop = (m_q.size() > 0) && bus.id_ready;
    req = !m_boot && !m_redir && !bus.br_taken &&
          ((m_q.size() + int'(m_infl) - int'(pop)) < 2);
    hp  = (m_q.size() > 0) ? m_q[0] : 32'h0;
    check("imem_req",  32'(bus.imem_req), 32'(req));
    check("imem_addr", bus.imem_addr, m_fetch);
    check("if_valid",  32'(bus.if_valid), 32'(m_q.size() > 0));
    check("if_pc",     bus.if_pc, hp);
    check("if_inst",   bus.if_inst, (m_q.size() > 0) ? mem_word(hp) : 32'h0);
    br  = bus.br_taken;
    tgt = bus.br_target;
    @(posedge clk);
    if (br) begin
      m_q.delete();
      m_fetch = {tgt[31:2], 2'b00};
      m_infl  = 1'b0;
      m_redir = 1'b1;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_pc);
      if (req) begin
        m_infl_pc = m_fetch;
        m_fetch   = m_fetch + 32'd4;
        m_infl    = 1'b1;
      end else begin
        m_infl = 1'b0;
      end
      m_redir = 1'b0;
    end
    m_boot = 1'b0;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] hold_pc;
    logic [31:0] first_pc;
    bit          found;

    bus.id_ready  = 1'b1;
    bus.br_taken  = 1'b0;
    bus.br_target = '0;
    model_reset();

    // Reset state
    #12;
    check("rst_req",   32'(bus.imem_req), 32'd0);
    check("rst_addr",  bus.imem_addr, RST_PC);
    check("rst_valid", 32'(bus.if_valid), 32'd0);
    check("rst_inst",  bus.if_inst, 32'd0);
    check("rst_pc",    bus.if_pc, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // 1: stream from reset
    tick();
    check("t1_req1",  32'(bus.imem_req), 32'd1);
    check("t1_addr1", bus.imem_addr, RST_PC);
    tick();
    check("t1_addr2", bus.imem_addr, RST_PC + 32'd4);
    tick();
    check("t1_valid3", 32'(bus.if_valid), 32'd1);
    check("t1_pc3",    bus.if_pc, RST_PC);
    repeat (4) tick();

    // 2: five-cycle stall
    bus.id_ready = 1'b0;
    #1;
    hold_pc = bus.if_pc;
    for (int i = 0; i < 5; i++) begin
      check("t2_noreq", 32'(bus.imem_req), 32'd0);
      tick();
    end
    check("t2_hold_pc", bus.if_pc, hold_pc);
    check("t2_hold_inst", bus.if_inst, mem_word(hold_pc));
    bus.id_ready = 1'b1;
    repeat (6) tick();

    // 3: redirect with a full buffer
    bus.id_ready = 1'b0;
    repeat (3) tick();
    check("t3_full", 32'(bus.if_valid), 32'd1);
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c00_0100;
    tick();
    bus.br_taken = 1'b0;
    bus.id_ready = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      #1;
      check("t3_novalid", 32'(bus.if_valid), 32'd0);
      if (r == 2) begin
        check("t3_req",  32'(bus.imem_req), 32'd1);
        check("t3_addr", bus.imem_addr, 32'h1c00_0100);
      end
      tick();
    end
    check("t3_valid4", 32'(bus.if_valid), 32'd1);
    check("t3_pc4",    bus.if_pc, 32'h1c00_0100);
    repeat (3) tick();

    // 4: back-to-back redirects
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c00_0200;
    tick();
    bus.br_target = 32'h1c00_0300;
    tick();
    bus.br_taken = 1'b0;
    found = 1'b0;
    first_pc = '0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.if_valid) begin
        found = 1'b1;
        first_pc = bus.if_pc;
      end else begin
        tick();
      end
    end
    check("t4_found", 32'(found), 32'd1);
    check("t4_first_pc", first_pc, 32'h1c00_0300);
    repeat (3) tick();

    // 5: misaligned target, redirect coinciding with a pop
    check("t5_pop_valid", 32'(bus.if_valid), 32'd1);
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c00_0102;
    tick();
    bus.br_taken = 1'b0;
    tick();
    check("t5_req",  32'(bus.imem_req), 32'd1);
    check("t5_addr", bus.imem_addr, 32'h1c00_0100);
    repeat (4) tick();

    // PC wrap
    bus.br_taken  = 1'b1;
    bus.br_target = 32'hffff_fff8;
    tick();
    bus.br_taken = 1'b0;
    repeat (4) tick();
    check("wrap_addr", bus.imem_addr, 32'h0000_0004);
    repeat (4) tick();

    // 6: short reset pulse mid-stream
    #2;
    rstn = 1'b0;
    #1;
    check("t6_valid", 32'(bus.if_valid), 32'd0);
    check("t6_req",   32'(bus.imem_req), 32'd0);
    check("t6_addr",  bus.imem_addr, RST_PC);
    rstn = 1'b1;
    model_reset();
    repeat (3) tick();
    check("t6_valid3", 32'(bus.if_valid), 32'd1);
    check("t6_pc3",    bus.if_pc, RST_PC);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.id_ready = ($urandom_range(0, 3) != 0);
      bus.br_taken = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0)
        bus.br_target = 32'hffff_fff0 | 32'($urandom_range(0, 15));
      else
        bus.br_target = 32'h1c00_0000 | ($urandom() & 32'h0000_0fff);
      tick();
    end
    bus.br_taken = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
